// File: rtl/mul_ctrl_pkg.sv
// Shared types and helpers for the RV32M multiply request/response controller.
package mul_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PROD_W = 64;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  // [1] = rs1 signed, [0] = rs2 signed
  localparam logic [1:0] SIGN_SS = 2'b11;
  localparam logic [1:0] SIGN_SU = 2'b10;
  localparam logic [1:0] SIGN_UU = 2'b00;

  // Operand key identifying one multiplier product
  typedef struct packed {
    logic [1:0]      sign;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } mul_key_t;

  function automatic logic [1:0] op_sign(input mul_op_t op);
    case (op)
      MUL, MULH: return SIGN_SS;
      MULHSU:    return SIGN_SU;
      default:   return SIGN_UU;
    endcase
  endfunction

  function automatic logic op_hi(input mul_op_t op);
    return op != MUL;
  endfunction

  function automatic logic [XLEN-1:0] sel_word(input logic [PROD_W-1:0] prod, input logic hi);
    return hi ? prod[PROD_W-1:XLEN] : prod[XLEN-1:0];
  endfunction

endpackage

// File: rtl/mul_ctrl_cache.sv
// One-entry product cache: operand/sign tag compare plus 64-bit product storage.
module mul_ctrl_cache
  import mul_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  mul_key_t          i_lookup_key,
  input  logic              i_lookup_any_sign,
  output logic              o_hit_c,
  input  logic              i_fill_en,
  input  mul_key_t          i_fill_key,
  input  logic [PROD_W-1:0] i_fill_prod,
  output logic [PROD_W-1:0] o_prod
);

  logic              r_valid;
  mul_key_t          r_key;
  logic [PROD_W-1:0] r_prod;

  logic     w_valid;
  mul_key_t w_key;

  // A lookup during a fill sees the incoming entry, since that is what the cache holds next cycle
  assign w_valid = r_valid | i_fill_en;
  assign w_key   = i_fill_en ? i_fill_key : r_key;

  assign o_hit_c = w_valid
                 & (i_lookup_key.a == w_key.a)
                 & (i_lookup_key.b == w_key.b)
                 & (i_lookup_any_sign | (i_lookup_key.sign == w_key.sign));

  assign o_prod = r_prod;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_key   <= '0;
      r_prod  <= '0;
    end else if (i_fill_en) begin
      r_valid <= 1'b1;
      r_key   <= i_fill_key;
      r_prod  <= i_fill_prod;
    end
  end

endmodule

// File: rtl/mul_ctrl.sv
// EX-stage controller for the RV32M multiplier: issues requests, selects the
// result word and serves repeated operand pairs from a one-entry product cache.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W    = 5,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              mul_in_valid,
  input  logic              mul_in_ready,
  output logic [1:0]        mul_in_sign,
  output logic [XLEN-1:0]   mul_in_a,
  output logic [XLEN-1:0]   mul_in_b,
  output logic              mul_flush,
  input  logic              mul_out_valid,
  output logic              mul_out_ready,
  input  logic [PROD_W-1:0] mul_out_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend_hi;
  logic [TAG_W-1:0] r_pend_tag;
  mul_key_t         r_pend_key;

  mul_op_t           w_op;
  mul_key_t          w_key;
  logic              w_block;
  logic              w_prod_fire;
  logic              w_cache_hit_c;
  logic              w_hit;
  logic              w_accept;
  logic [PROD_W-1:0] w_cache_prod;

  assign w_op    = mul_op_t'(in_op);
  assign w_key   = '{sign: op_sign(w_op), a: in_a, b: in_b};
  assign w_block = flush | reset;

  assign mul_in_sign = w_key.sign;
  assign mul_in_a    = in_a;
  assign mul_in_b    = in_b;
  assign mul_flush   = flush;
  assign out_tag     = r_pend_tag;

  // Only a product actually delivered to writeback is cached
  assign w_prod_fire = (r_state == ST_BUSY) & mul_out_valid & out_ready & ~w_block;

  mul_ctrl_cache u_cache (
    .clock             (clock),
    .reset             (reset),
    .i_lookup_key      (w_key),
    .i_lookup_any_sign (w_op == MUL),
    .o_hit_c           (w_cache_hit_c),
    .i_fill_en         (w_prod_fire),
    .i_fill_key        (r_pend_key),
    .i_fill_prod       (mul_out_prod),
    .o_prod            (w_cache_prod)
  );

  assign w_hit = CACHE_EN & w_cache_hit_c;

  // Handshakes, result mux and next state
  always_comb begin
    w_state_nxt   = r_state;
    in_ready      = 1'b0;
    mul_in_valid  = 1'b0;
    mul_out_ready = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    w_accept      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        in_ready = w_hit | mul_in_ready;
      end
      ST_BUSY: begin
        out_valid     = mul_out_valid;
        out_data      = sel_word(mul_out_prod, r_pend_hi);
        mul_out_ready = out_ready;
        in_ready      = out_ready & mul_out_valid & (w_hit | mul_in_ready);
        if (out_ready & mul_out_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HIT: begin
        out_valid = 1'b1;
        out_data  = sel_word(w_cache_prod, r_pend_hi);
        in_ready  = out_ready & (w_hit | mul_in_ready);
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Flush drains the multiplier output and kills the op in flight
    if (w_block) begin
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      mul_out_ready = flush;
      w_state_nxt   = ST_IDLE;
    end

    w_accept     = in_valid & in_ready;
    mul_in_valid = w_accept & ~w_hit;
    if (w_accept) begin
      w_state_nxt = w_hit ? ST_HIT : ST_BUSY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pend_hi  <= 1'b0;
      r_pend_tag <= '0;
      r_pend_key <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pend_hi  <= op_hi(w_op);
        r_pend_tag <= in_tag;
        if (!w_hit) begin
          r_pend_key <= w_key;
        end
      end
    end
  end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- EX-stage requester and consumer for the RV32M multiply unit.
- Accepts decoded MUL/MULH/MULHSU/MULHU ops from issue and drives the multiplier's valid/ready request port with sign-extended operands.
- Consumes the 64-bit product, selects the low or high word and returns a tagged 32-bit result to writeback.
- A one-entry product cache serves a MULH[[S]U]/MUL pair on identical operands without reissuing.

Parameters:
- TAG_W, 5, width of the destination-register tag carried with each op.
- CACHE_EN, 1, 1 enables the product cache; 0 forces every op to miss.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; kills the op in flight and blocks new accepts.
- in_valid  in  1  issue op valid.
- in_ready  out  1  block accepts the op this cycle.
- in_op  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- in_a, in_b  in  32  rs1, rs2 values.
- in_tag  in  TAG_W  destination tag.
- mul_in_valid  out  1  request to the multiplier.
- mul_in_ready  in  1  multiplier accepts the request.
- mul_in_sign  out  2  [1]=a signed, [0]=b signed.
- mul_in_a, mul_in_b  out  32  operands to the multiplier.
- mul_flush  out  1  flush forwarded to the multiplier.
- mul_out_valid  in  1  product valid.
- mul_out_ready  out  1  product consumed.
- mul_out_prod  in  64  product.
- out_valid  out  1  result valid to writeback.
- out_ready  in  1  writeback accepts the result.
- out_data  out  32  selected result word.
- out_tag  out  TAG_W  destination tag of the result.

Behaviour:
- Sign map: MUL=2'b11, MULH=2'b11, MULHSU=2'b10, MULHU=2'b00.
- Word select: hi=(op!=MUL); out_data = hi ? prod[63:32] : prod[31:0].
- State registers:
  - state: ST_IDLE / ST_BUSY / ST_HIT.
  - pend_hi, pend_tag, pend_a, pend_b, pend_sign.
  - cache_valid, cache_a, cache_b, cache_sign, cache_prod[63:0].
- Hit condition: CACHE_EN & cache_valid & in_a==cache_a & in_b==cache_b & (op==MUL | sign==cache_sign). A MUL hits on any cached sign because the low word is sign-independent.
- in_ready:
  - 0 whenever flush=1.
  - ST_IDLE: 1 on a hit, else mul_in_ready.
  - ST_BUSY: out_ready & mul_out_valid.
  - ST_HIT: out_ready.
- Miss accept:
  - mul_in_valid = in_valid & in_ready & ~hit & ~flush.
  - Operands pass through combinationally.
  - Capture pend_*; next state ST_BUSY.
- Hit accept: no multiplier request; capture pend_hi and pend_tag; next state ST_HIT.
- ST_BUSY:
  - out_valid = mul_out_valid; out_data comes from mul_out_prod.
  - mul_out_ready = out_ready.
  - On mul_out fire: load cache from pend_a/b/sign and mul_out_prod; set cache_valid. Next state is ST_IDLE, unless a new op is accepted in the same cycle, in which case go to ST_BUSY or ST_HIT per that op.
  - Result latency is 1 cycle after accept; back-to-back ops sustain 1 op/cycle while out_ready=1.
- ST_HIT:
  - out_valid=1; out_data comes from cache_prod.
  - On fire: next state per any same-cycle accept, else ST_IDLE.
- Flush:
  - mul_flush=flush and mul_out_ready=1 for that cycle.
  - State goes to ST_IDLE and out_valid is forced 0.
  - No cache update that cycle; cache contents are kept, since they are value-based and never stale.
  - No multiplier result may be observed after a flush.
- Reset: state=ST_IDLE, cache_valid=0. All of out_valid, mul_in_valid, mul_out_ready, mul_flush are 0.
  - Reset mid-BUSY discards the product; the multiplier is reset on the same reset.
- Writeback stall: with out_ready=0, out_data and out_tag hold stable and in_ready=0.
- Simultaneous flush and in_valid: the op is dropped with no multiplier request.

Decomposition:
- Shared package:
  - mul_op_t enum (MUL, MULH, MULHSU, MULHU).
  - Sign constants SIGN_SS=2'b11, SIGN_SU=2'b10, SIGN_UU=2'b00.
  - op-to-sign and op-to-hi helper functions.
- Local typedef: state_t (ST_IDLE, ST_BUSY, ST_HIT).
- Optional sub-module mul_ctrl_cache: one-entry tag compare plus product storage, with lookup and fill ports. Everything else stays flat.

Test Plan:
- MULHU a=0xFFFFFFFF, b=0x2, out_ready=1 -> mul_in_sign=00; next cycle out_data=0x00000001 with matching out_tag.
- MULH then MUL, both a=0xFFFFFFFE, b=0x3 -> MULH gives 0xFFFFFFFF via the multiplier; MUL hits (no mul_in_valid) with out_data=0xFFFFFFFA.
- MULHSU a=0x80000000, b=0x80000000 after a cached MULH on the same operands -> miss with sign 10; out_data=0xC0000000.
- Result pending and out_ready=0 for 3 cycles -> out_valid held, data stable, in_ready=0; accept on the 4th cycle together with a new op -> back-to-back issue.
- flush asserted in ST_BUSY -> mul_flush=1, out_valid=0 next cycle, cache unchanged; a repeat of the prior cached op still hits.
- reset asserted in ST_HIT -> next cycle state ST_IDLE, out_valid=0, cache_valid=0; the same op now misses.
